// File: rtl/ia_tile_feeder.sv
// Activation/weight feeder for one systolic tile: loads SIZE weight rows per pass,
// then streams cfg_rows activation rows, repeating for cfg_passes partial-sum passes.
`timescale 1ns/1ps
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; cfg_* captured on the launch edge
// WLOAD     | SIZE cycles of weight reads for the current pass
// STREAM    | cfg_rows cycles of activation reads for the current pass
// WAIT_PS   | waiting for partial_sum_calc_over before the next pass
// WAIT_TILE | waiting for tile_calc_over after the final pass
// FIN       | one-cycle done pulse, busy low
module ia_tile_feeder #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [CNT_WIDTH-1:0]                      cfg_rows,
  input  logic [CNT_WIDTH-1:0]                      cfg_passes,
  input  logic [ADDR_WIDTH-1:0]                     cfg_ia_base,
  input  logic [ADDR_WIDTH-1:0]                     cfg_wt_base,
  output logic                                      wt_rd_en,
  output logic [ADDR_WIDTH-1:0]                     wt_rd_addr,
  output logic                                      ia_rd_en,
  output logic [ADDR_WIDTH-1:0]                     ia_rd_addr,
  input  logic signed [SIZE-1:0][DATA_WIDTH-1:0]    ia_rd_data,
  output logic                                      store_weight_req,
  output logic signed [SIZE-1:0][DATA_WIDTH-1:0]    ia_vec_in,
  output logic                                      ia_row_valid,
  output logic                                      ia_calc_done,
  output logic                                      ia_is_init_data,
  input  logic                                      partial_sum_calc_over,
  input  logic                                      tile_calc_over,
  output logic                                      busy,
  output logic                                      done
);

  typedef enum logic [2:0] {IDLE, WLOAD, STREAM, WAIT_PS, WAIT_TILE, FIN} state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  rows_q, passes_q, pass_idx, cnt;
  logic [ADDR_WIDTH-1:0] wt_ptr, ia_ptr;
  logic                  cnt_tc, last_pass, launch, zero_job;

  assign cnt_tc    = (cnt == '0);
  assign last_pass = (pass_idx == passes_q - CNT_WIDTH'(1));
  assign launch    = (state == IDLE) && start;
  assign zero_job  = (cfg_rows == '0) || (cfg_passes == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wt_rd_en  = 1'b0;
    ia_rd_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = zero_job ? FIN : WLOAD;
      end
      WLOAD: begin
        wt_rd_en = 1'b1;
        busy     = 1'b1;
        if (cnt_tc) state_nxt = STREAM;
      end
      STREAM: begin
        ia_rd_en = 1'b1;
        busy     = 1'b1;
        if (cnt_tc) state_nxt = last_pass ? WAIT_TILE : WAIT_PS;
      end
      WAIT_PS: begin
        busy = 1'b1;
        if (partial_sum_calc_over) state_nxt = WLOAD;
      end
      WAIT_TILE: begin
        busy = 1'b1;
        if (tile_calc_over) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pass address offsets (p*SIZE, p*rows) are contiguous, so the pointers just keep counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q   <= '0;
      passes_q <= '0;
      pass_idx <= '0;
      cnt      <= '0;
      wt_ptr   <= '0;
      ia_ptr   <= '0;
    end else if (launch) begin
      rows_q   <= cfg_rows;
      passes_q <= cfg_passes;
      pass_idx <= '0;
      cnt      <= CNT_WIDTH'(SIZE - 1);
      wt_ptr   <= cfg_wt_base;
      ia_ptr   <= cfg_ia_base;
    end else begin
      case (state)
        WLOAD: begin
          wt_ptr <= wt_ptr + ADDR_WIDTH'(1);
          cnt    <= cnt_tc ? rows_q - CNT_WIDTH'(1) : cnt - CNT_WIDTH'(1);
        end
        STREAM: begin
          ia_ptr <= ia_ptr + ADDR_WIDTH'(1);
          if (!cnt_tc) cnt <= cnt - CNT_WIDTH'(1);
        end
        WAIT_PS: begin
          if (partial_sum_calc_over) begin
            pass_idx <= pass_idx + CNT_WIDTH'(1);
            cnt      <= CNT_WIDTH'(SIZE - 1);
          end
        end
        default: ;
      endcase
    end
  end

  // Core-side strobes line up with the data returning one cycle after each read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_weight_req <= 1'b0;
      ia_row_valid     <= 1'b0;
      ia_calc_done     <= 1'b0;
      ia_is_init_data  <= 1'b0;
    end else begin
      store_weight_req <= wt_rd_en;
      ia_row_valid     <= ia_rd_en;
      ia_calc_done     <= ia_rd_en && cnt_tc;
      ia_is_init_data  <= ia_rd_en && (pass_idx == '0);
    end
  end

  assign wt_rd_addr = wt_rd_en ? wt_ptr : '0;
  assign ia_rd_addr = ia_rd_en ? ia_ptr : '0;
  assign ia_vec_in  = ia_row_valid ? ia_rd_data : '0;

endmodule
